mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin on ties, 0 = fixed priority with port B winning ties.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 read_a  input  1  port A (instruction fetch) read request; port A is read-only.
REQ-005 address_a  input  16  port A word address.
REQ-006 resp_a  output  1  port A completion, one-cycle pulse.
REQ-007 rdata_a  output  16  port A read data, valid only while resp_a=1.
REQ-008 read_b / write_b  input  1 / 1  port B (data memory) read and write requests.
REQ-009 wmask_b  input  2  port B byte mask.
REQ-010 address_b / wdata_b  input  16 / 16  port B address and write data.
REQ-011 resp_b  output  1  port B completion, one-cycle pulse.
REQ-012 rdata_b  output  16  port B read data, valid only while resp_b=1.
REQ-013 mem_read / mem_write  output  1 / 1  shared memory request strobes.
REQ-014 mem_wmask / mem_address / mem_wdata  output  2 / 16 / 16  shared memory request fields.
REQ-015 mem_resp  input  1  shared memory completion.
REQ-016 mem_rdata  input  16  shared memory read data.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SERVE_A and SERVE_B.
REQ-018 A port SHALL be pending when read_a=1 (port A) or when read_b|write_b=1 (port B).
REQ-019 In IDLE with exactly one port pending, the FSM SHALL enter that port's SERVE state on the next edge.
REQ-020 In IDLE with both ports pending and RR_EN=1, the grant SHALL go to the port not recorded in last_grant; with RR_EN=0, port B SHALL win.
REQ-021 On every grant, the arbiter SHALL update last_grant and latch address, operation, wdata and wmask into registers.
REQ-022 The mem_* outputs SHALL be driven only from the latched registers, so they stay stable for the whole transaction.
REQ-023 If read_b and write_b are both 1 at grant, the arbiter SHALL treat the request as a write.
REQ-024 Latched reads SHALL drive mem_wmask=2'b11 and mem_wdata=16'h0000.
REQ-025 In IDLE, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0 and mem_wmask=0.
REQ-026 In SERVE_x, the matching strobe SHALL be held high until the cycle in which mem_resp=1.
REQ-027 In the mem_resp=1 cycle, resp_x SHALL equal 1 combinationally and rdata_x SHALL equal mem_rdata.
REQ-028 After that mem_resp=1 cycle, the FSM SHALL return to IDLE on the next edge.
REQ-029 Latency: request at cycle 0 -> mem strobe from cycle 1 -> resp_x in the same cycle as mem_resp.
REQ-030 The first re-arbitration after a completion SHALL occur in the cycle after resp_x.
REQ-031 There SHALL be no back-to-back transactions without an IDLE cycle between them.
REQ-032 resp_a and resp_b SHALL never both be 1 in the same cycle.
REQ-033 A resp SHALL never be asserted to a port that is not currently in its SERVE state.
REQ-034 mem_resp in IDLE SHALL be ignored: no resp pulse and no state change.
REQ-035 If a requester drops its request mid-transaction, the transaction SHALL still complete and resp_x SHALL still pulse.
REQ-036 When not asserting resp_x, rdata_x SHALL be 16'h0000.
REQ-037 With RR_EN=1 and both ports continuously pending, grants SHALL strictly alternate A, B, A, B...

Reset
REQ-038 While reset_n=0, the FSM SHALL be held in IDLE, last_grant=A, all latched registers=0, and resp_a=resp_b=0.
REQ-039 All mem_* outputs SHALL be 0 during reset, taking effect immediately without waiting for a clock edge.
REQ-040 If reset is asserted mid-transaction, the transaction SHALL be abandoned with no resp pulse.
REQ-041 A mem_resp arriving after reset deassertion but before a new grant SHALL be ignored.

Verification
REQ-042 Scenario, single read on port A: read_a=1, address_a=16'h0040, mem_resp on the 3rd cycle of mem_read with mem_rdata=16'h1234 -> mem_address=16'h0040, then resp_a pulses once with rdata_a=16'h1234, and resp_b=0.
REQ-043 Scenario, write on port B: write_b=1, address_b=16'h1000, wdata_b=16'hBEEF, wmask_b=2'b01 -> mem_write=1 with those exact field values, then resp_b pulses on mem_resp, and mem_read stays 0 throughout.
REQ-044 Scenario, sustained tie with RR_EN=1: both ports pending for 4 transactions after reset -> grant order B, A, B, A (first tie goes to B because last_grant=A).
REQ-045 Scenario, sustained tie with RR_EN=0: both ports pending for 3 transactions -> B, B, B, with A never granted while B is pending.
REQ-046 Scenario, mid-transaction reset: reset_n pulsed low during SERVE_B before mem_resp -> mem_* outputs drop to 0 asynchronously, no resp_b pulse, a stray mem_resp after release is ignored, and the next read_a is served normally.
REQ-047 Scenario, request changes mid-transaction: address_a changes while SERVE_A is waiting on mem_resp -> mem_address holds the originally latched value.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of the
// memory arbiter. The arbiter takes the slave view; the requesters and the
// memory model together take the master view.
//
// Handshake: a requester raises read_x/write_x (its "valid") and keeps its
// fields steady until the arbiter grants it; the request is captured at grant,
// so fields may change afterwards. Completion is a one-cycle resp_x pulse, and
// rdata_x is meaningful only in that cycle. On the memory side, mem_read/mem_write
// stay high with stable fields until the cycle where mem_resp (the "ready")
// is seen high; that cycle ends the transfer.
interface mem_arbiter_if;
  // Port A: instruction fetch, read-only
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  // Port B: data memory, read or write
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  // Shared memory port
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport slave (
    input  read_a, address_a,
    output resp_a, rdata_a,
    input  read_b, write_b, wmask_b, address_b, wdata_b,
    output resp_b, rdata_b,
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output read_a, address_a,
    input  resp_a, rdata_a,
    output read_b, write_b, wmask_b, address_b, wdata_b,
    input  resp_b, rdata_b,
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port A (read-only fetch) and port B (load/store)
// share one memory. One transaction at a time, with an IDLE cycle between
// transactions. Ties go round-robin (RR_EN=1) or to port B (RR_EN=0).
// The granted request is captured in registers so the memory sees stable
// fields for the whole transaction regardless of what the requester does.
module mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus,
  output logic [1:0]   state_dbg,
  output logic         last_grant_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant_a;
  logic        grant_b;
  logic        pend_a;
  logic        pend_b;

  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [1:0]  lat_wmask;
  logic        lat_write;

  assign pend_a = bus.read_a;
  assign pend_b = bus.read_b | bus.write_b;

  // Grant decision and next state; grants only happen from IDLE.
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_a && pend_b) begin
          if (RR_EN && (last_grant == GRANT_B)) grant_a = 1'b1;
          else                                  grant_b = 1'b1;
        end else if (pend_a) begin
          grant_a = 1'b1;
        end else if (pend_b) begin
          grant_b = 1'b1;
        end
        if (grant_a)      state_nxt = SERVE_A;
        else if (grant_b) state_nxt = SERVE_B;
      end
      SERVE_A, SERVE_B: begin
        if (bus.mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture the winning request and remember who won. Reads carry a full
  // byte mask and zero write data; a B request with both read and write
  // raised is treated as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_A;
      lat_addr   <= 16'h0000;
      lat_wdata  <= 16'h0000;
      lat_wmask  <= 2'b00;
      lat_write  <= 1'b0;
    end else if (grant_a) begin
      last_grant <= GRANT_A;
      lat_addr   <= bus.address_a;
      lat_wdata  <= 16'h0000;
      lat_wmask  <= 2'b11;
      lat_write  <= 1'b0;
    end else if (grant_b) begin
      last_grant <= GRANT_B;
      lat_addr   <= bus.address_b;
      lat_write  <= bus.write_b;
      lat_wdata  <= bus.write_b ? bus.wdata_b : 16'h0000;
      lat_wmask  <= bus.write_b ? bus.wmask_b : 2'b11;
    end
  end

  // Memory-side outputs come only from registers, forced to zero in IDLE.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = 16'h0000;
    bus.mem_wdata   = 16'h0000;
    bus.mem_wmask   = 2'b00;
    if (state != IDLE) begin
      bus.mem_read    = ~lat_write;
      bus.mem_write   = lat_write;
      bus.mem_address = lat_addr;
      bus.mem_wdata   = lat_wdata;
      bus.mem_wmask   = lat_wmask;
    end
  end

  // Completion is routed only to the port being served; data is zero otherwise.
  always_comb begin
    bus.resp_a  = (state == SERVE_A) && bus.mem_resp;
    bus.resp_b  = (state == SERVE_B) && bus.mem_resp;
    bus.rdata_a = bus.resp_a ? bus.mem_rdata : 16'h0000;
    bus.rdata_b = bus.resp_b ? bus.mem_rdata : 16'h0000;
  end

  assign state_dbg      = state;
  assign last_grant_dbg = last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance and one
// fixed-priority instance, driven from a single sequence.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_A    = 2'd1;
  localparam logic [1:0] S_B    = 2'd2;

  logic [1:0] st_r, st_f;
  logic       lg_r, lg_f;

  mem_arbiter_if br ();
  mem_arbiter_if bf ();

  mem_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset_n(reset_n), .bus(br),
    .state_dbg(st_r), .last_grant_dbg(lg_r)
  );

  mem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .bus(bf),
    .state_dbg(st_f), .last_grant_dbg(lg_f)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    br.read_a = 0; br.address_a = 0; br.read_b = 0; br.write_b = 0;
    br.wmask_b = 0; br.address_b = 0; br.wdata_b = 0; br.mem_resp = 0; br.mem_rdata = 0;
    bf.read_a = 0; bf.address_a = 0; bf.read_b = 0; bf.write_b = 0;
    bf.wmask_b = 0; bf.address_b = 0; bf.wdata_b = 0; bf.mem_resp = 0; bf.mem_rdata = 0;
  endtask

  task automatic set_mem(input bit sel, input logic resp, input logic [15:0] data);
    if (sel) begin bf.mem_resp = resp; bf.mem_rdata = data; end
    else     begin br.mem_resp = resp; br.mem_rdata = data; end
  endtask

  function automatic logic [1:0] cur_state(input bit sel);
    return sel ? st_f : st_r;
  endfunction

  function automatic logic cur_resp_a(input bit sel);
    return sel ? bf.resp_a : br.resp_a;
  endfunction

  function automatic logic cur_resp_b(input bit sel);
    return sel ? bf.resp_b : br.resp_b;
  endfunction

  // Serve n transactions with requests held by the caller; grants are
  // compared against exp_q. Starts and ends at a falling edge in IDLE.
  task automatic run_ties(input bit sel, input int n);
    bit         seen;
    logic [1:0] g;
    for (int i = 0; i < n; i++) begin
      seen = 0;
      for (int c = 0; c < 8 && !seen; c++) begin
        tick();
        sample();
        if (cur_state(sel) != S_IDLE) seen = 1;
      end
      check("grant_seen", {31'd0, seen}, 32'd1);
      g = cur_state(sel);
      check("grant_order", {30'd0, g}, {30'd0, exp_q.pop_front()});
      tick();
      set_mem(sel, 1'b1, 16'hC000 + 16'(i));
      sample();
      check("tie_resp_a", {31'd0, cur_resp_a(sel)}, {31'd0, g == S_A});
      check("tie_resp_b", {31'd0, cur_resp_b(sel)}, {31'd0, g == S_B});
      tick();
      set_mem(sel, 1'b0, 16'h0000);
      sample();
      check("tie_idle_gap", {30'd0, cur_state(sel)}, {30'd0, S_IDLE});
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset_n = 1'b0;
    clear_inputs();

    // Reset state
    sample();
    check("rst_state", {30'd0, st_r}, 32'd0);
    check("rst_last_grant", {31'd0, lg_r}, 32'd0);
    check("rst_mem_strobes", {30'd0, br.mem_read, br.mem_write}, 32'd0);
    check("rst_mem_fields", {br.mem_address, br.mem_wdata}, 32'd0);
    check("rst_resp", {30'd0, br.resp_a, br.resp_b}, 32'd0);
    tick();
    reset_n = 1'b1;
    sample();

    // Single read on A; address changes after grant
    tick();
    br.read_a = 1; br.address_a = 16'h0040;
    sample();
    check("a_no_strobe_cycle0", {31'd0, br.mem_read}, 32'd0);
    tick();
    br.read_a = 0; br.address_a = 16'hFFFF;
    sample();
    check("a_state", {30'd0, st_r}, {30'd0, S_A});
    check("a_mem_read", {31'd0, br.mem_read}, 32'd1);
    check("a_mem_addr", {16'd0, br.mem_address}, 32'h0040);
    check("a_mem_wmask_wdata", {14'd0, br.mem_wmask, br.mem_wdata}, {14'd0, 2'b11, 16'h0000});
    tick();
    sample();
    check("a_addr_held", {16'd0, br.mem_address}, 32'h0040);
    check("a_no_resp_yet", {15'd0, br.resp_a, br.rdata_a}, 32'd0);
    tick();
    br.mem_resp = 1; br.mem_rdata = 16'h1234;
    sample();
    check("a_resp", {31'd0, br.resp_a}, 32'd1);
    check("a_rdata", {16'd0, br.rdata_a}, 32'h1234);
    check("a_resp_b_quiet", {15'd0, br.resp_b, br.rdata_b}, 32'd0);
    tick();
    br.mem_resp = 0; br.mem_rdata = 0;
    sample();
    check("a_back_idle", {30'd0, st_r}, 32'd0);
    check("a_idle_outputs", {br.mem_read, br.mem_write, 14'd0, br.mem_address}, 32'd0);

    // Stray mem_resp in IDLE
    br.mem_resp = 1; br.mem_rdata = 16'hDEAD;
    #2;
    check("idle_resp_ignored", {30'd0, br.resp_a, br.resp_b}, 32'd0);
    tick();
    sample();
    check("idle_resp_state", {30'd0, st_r}, 32'd0);
    tick();
    br.mem_resp = 0; br.mem_rdata = 0;
    sample();

    // Write on B; request dropped after grant
    tick();
    br.write_b = 1; br.address_b = 16'h1000; br.wdata_b = 16'hBEEF; br.wmask_b = 2'b01;
    sample();
    tick();
    br.write_b = 0;
    sample();
    check("bw_state", {30'd0, st_r}, {30'd0, S_B});
    check("bw_strobes", {30'd0, br.mem_read, br.mem_write}, 32'd1);
    check("bw_fields", {br.mem_address, br.mem_wdata}, 32'h1000BEEF);
    check("bw_wmask", {30'd0, br.mem_wmask}, 32'd1);
    tick();
    br.mem_resp = 1; br.mem_rdata = 16'h5A5A;
    sample();
    check("bw_resp", {30'd0, br.resp_a, br.resp_b}, 32'd1);
    check("bw_read_low", {31'd0, br.mem_read}, 32'd0);
    tick();
    br.mem_resp = 0; br.mem_rdata = 0;
    sample();
    check("bw_idle", {30'd0, st_r}, 32'd0);

    // Read on B: mask forced full, write data zeroed
    tick();
    br.read_b = 1; br.address_b = 16'h2222; br.wdata_b = 16'h1111; br.wmask_b = 2'b01;
    sample();
    tick();
    br.read_b = 0;
    sample();
    check("br_strobes", {30'd0, br.mem_read, br.mem_write}, 32'd2);
    check("br_fields", {br.mem_address, br.mem_wdata}, 32'h22220000);
    check("br_wmask", {30'd0, br.mem_wmask}, 32'd3);
    tick();
    br.mem_resp = 1; br.mem_rdata = 16'h9876;
    sample();
    check("br_rdata", {15'd0, br.resp_b, br.rdata_b}, {15'd0, 1'b1, 16'h9876});
    tick();
    br.mem_resp = 0; br.mem_rdata = 0;
    sample();

    // B with read and write both high is a write
    tick();
    br.read_b = 1; br.write_b = 1; br.address_b = 16'h3000; br.wdata_b = 16'h00FF; br.wmask_b = 2'b10;
    sample();
    tick();
    br.read_b = 0; br.write_b = 0;
    sample();
    check("brw_strobes", {30'd0, br.mem_read, br.mem_write}, 32'd1);
    check("brw_fields", {br.mem_address, br.mem_wdata}, 32'h300000FF);
    check("brw_wmask", {30'd0, br.mem_wmask}, 32'd2);
    tick();
    br.mem_resp = 1;
    sample();
    tick();
    br.mem_resp = 0;
    sample();

    // Reset in the middle of a B transaction
    tick();
    br.read_b = 1; br.address_b = 16'h4444;
    sample();
    tick();
    br.read_b = 0;
    sample();
    check("mr_serving", {30'd0, st_r}, {30'd0, S_B});
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_async_strobes", {30'd0, br.mem_read, br.mem_write}, 32'd0);
    check("mr_async_addr", {16'd0, br.mem_address}, 32'd0);
    check("mr_async_state", {30'd0, st_r}, 32'd0);
    br.mem_resp = 1; br.mem_rdata = 16'hBAD0;
    sample();
    check("mr_no_resp", {30'd0, br.resp_a, br.resp_b}, 32'd0);
    tick();
    reset_n = 1'b1;
    sample();
    check("mr_stray_resp", {30'd0, br.resp_a, br.resp_b}, 32'd0);
    tick();
    br.mem_resp = 0; br.mem_rdata = 0;
    sample();
    check("mr_still_idle", {30'd0, st_r}, 32'd0);
    tick();
    br.read_a = 1; br.address_a = 16'h0044;
    sample();
    tick();
    br.read_a = 0;
    sample();
    check("mr_next_read", {15'd0, br.mem_read, br.mem_address}, {15'd0, 1'b1, 16'h0044});
    tick();
    br.mem_resp = 1; br.mem_rdata = 16'h7777;
    sample();
    check("mr_next_resp", {15'd0, br.resp_a, br.rdata_a}, {15'd0, 1'b1, 16'h7777});
    tick();
    br.mem_resp = 0; br.mem_rdata = 0;
    sample();

    // Round-robin tie from reset: B, A, B, A
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sample();
    br.read_a = 1; br.address_a = 16'h0100;
    br.read_b = 1; br.address_b = 16'h0200;
    exp_q.push_back(S_B); exp_q.push_back(S_A);
    exp_q.push_back(S_B); exp_q.push_back(S_A);
    run_ties(1'b0, 4);
    br.read_a = 0; br.read_b = 0;

    // Fixed priority tie: B, B, B, then A once B drops
    bf.read_a = 1; bf.address_a = 16'h0300;
    bf.read_b = 1; bf.address_b = 16'h0400;
    exp_q.push_back(S_B); exp_q.push_back(S_B); exp_q.push_back(S_B);
    run_ties(1'b1, 3);
    bf.read_b = 0;
    exp_q.push_back(S_A);
    run_ties(1'b1, 1);
    bf.read_a = 0;

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
